// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fpga_cfg_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } cfg_state_t;

  // Words per frame: ceil(cfg_width / in_width).
  function automatic int calc_wpf(input int cfg_width, input int in_width);
    return (cfg_width + in_width - 1) / in_width;
  endfunction

endpackage

// File: rtl/cfg_frame_assembler.sv
// Word-to-frame deserialiser: packs IN_WIDTH words LSB-first into a CFG_WIDTH frame.
// Latency: a word strobed at cycle N appears in frame_o at N+1; frame_full_o is combinational on the last word.
// Backpressure: none internally; the caller only strobes words it has accepted.
// Ports: clk_i/rst_ni clock and async active-low reset; word_stb_i accepts word_i;
//        clear_i restarts at word 0 (frame contents kept); frame_o assembled frame;
//        frame_full_o high when the strobed word completes the frame.
module cfg_frame_assembler
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_WIDTH = 320,
  parameter int IN_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 word_stb_i,
  input  logic                 clear_i,
  input  logic [IN_WIDTH-1:0]  word_i,
  output logic [CFG_WIDTH-1:0] frame_o,
  output logic                 frame_full_o
);

  localparam int WPF = calc_wpf(CFG_WIDTH, IN_WIDTH);
  localparam int WW  = (WPF > 1) ? $clog2(WPF) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(WPF - 1);

  logic [WW-1:0]        word_idx_q, word_idx_d;
  logic [CFG_WIDTH-1:0] frame_q, frame_d;

  assign frame_o      = frame_q;
  assign frame_full_o = word_stb_i && (word_idx_q == LAST_WORD);

  always_comb begin
    word_idx_d = word_idx_q;
    frame_d    = frame_q;
    if (clear_i) begin
      word_idx_d = '0;
    end else if (word_stb_i) begin
      word_idx_d = (word_idx_q == LAST_WORD) ? '0 : word_idx_q + 1'b1;
      // Only frame bits covered by the current word slot are written; the
      // upper bits of a final partial word have no destination and drop out.
      for (int b = 0; b < CFG_WIDTH; b++) begin
        if (int'(word_idx_q) == b / IN_WIDTH) begin
          frame_d[b] = word_i[b % IN_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_idx_q <= '0;
      frame_q    <= '0;
    end else begin
      word_idx_q <= word_idx_d;
      frame_q    <= frame_d;
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams bitstream words into frames, writes each frame one-hot into the fabric, then settles and enables.
// Latency: WPF+1 cycles per frame at full rate; NUM_FRAMES*(WPF+1)+SETTLE_CYCLES from first LOAD to DONE.
// Backpressure: in_ready is high only in LOAD; in_valid stalls simply delay the pass.
// Ports: clock/rst (async active-low); start begins a pass from IDLE or DONE;
//        in_data/in_valid/in_ready word stream; configs_in/configs_en frame write to fabric;
//        ff_en high in DONE; rdy one cycle behind ff_en; busy in LOAD/WRITE/SETTLE.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_WIDTH     = 320,
  parameter int NUM_FRAMES    = 172,
  parameter int IN_WIDTH      = 32,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CFG_WIDTH-1:0]  configs_in,
  output logic [NUM_FRAMES-1:0] configs_en,
  output logic                  ff_en,
  output logic                  rdy,
  output logic                  busy
);

  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [FW-1:0]         LAST_FRAME  = FW'(NUM_FRAMES - 1);
  localparam logic [SW-1:0]         SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [NUM_FRAMES-1:0] FRAME0_EN   = NUM_FRAMES'(1);

  cfg_state_t    state_q, state_d;
  logic [FW-1:0] frame_idx_q, frame_idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          rdy_q, rdy_d;
  logic          asm_clear;
  logic          word_stb;
  logic          frame_full;

  // All handshake/enable outputs decode registered state, so they are glitch
  // free and drop the moment an asynchronous reset forces IDLE.
  assign in_ready   = (state_q == LOAD);
  assign word_stb   = in_valid && in_ready;
  assign configs_en = (state_q == WRITE) ? (FRAME0_EN << frame_idx_q) : '0;
  assign ff_en      = (state_q == DONE);
  assign rdy        = rdy_q;
  assign busy       = (state_q == LOAD) || (state_q == WRITE) || (state_q == SETTLE);

  cfg_frame_assembler #(
    .CFG_WIDTH (CFG_WIDTH),
    .IN_WIDTH  (IN_WIDTH)
  ) u_asm (
    .clk_i        (clock),
    .rst_ni       (rst),
    .word_stb_i   (word_stb),
    .clear_i      (asm_clear),
    .word_i       (in_data),
    .frame_o      (configs_in),
    .frame_full_o (frame_full)
  );

  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    settle_d    = settle_q;
    asm_clear   = 1'b0;
    rdy_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          frame_idx_d = '0;
          asm_clear   = 1'b1;
        end
      end
      LOAD: begin
        if (frame_full) state_d = WRITE;
      end
      WRITE: begin
        if (frame_idx_q == LAST_FRAME) begin
          state_d  = SETTLE;
          settle_d = SETTLE_INIT;
        end else begin
          state_d     = LOAD;
          frame_idx_d = frame_idx_q + 1'b1;
          asm_clear   = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == '0) state_d = DONE;
        else                settle_d = settle_q - 1'b1;
      end
      DONE: begin
        // rdy follows ff_en by one cycle and must already be low in the
        // LOAD entry cycle of a restart.
        rdy_d = !start;
        if (start) begin
          state_d     = LOAD;
          frame_idx_d = '0;
          asm_clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      frame_idx_q <= '0;
      settle_q    <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_idx_q <= frame_idx_d;
      settle_q    <= settle_d;
      rdy_q       <= rdy_d;
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed self-checking bench for fpga_cfg_loader (CFG_WIDTH=8, IN_WIDTH=3, NUM_FRAMES=4, SETTLE_CYCLES=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fpga_cfg_loader;

  logic       clock;
  logic       rst;
  logic       start;
  logic [2:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] configs_in;
  logic [3:0] configs_en;
  logic       ff_en;
  logic       rdy;
  logic       busy;

  int n_chk;
  int n_fail;

  // Per-frame words and the hand-assembled frames they produce
  // (bits [7:6] take the low two bits of the third word).
  logic [2:0] words [4][3];
  logic [7:0] exp_frame [4];
  logic [7:0] exp_cur;

  fpga_cfg_loader #(
    .CFG_WIDTH     (8),
    .NUM_FRAMES    (4),
    .IN_WIDTH      (3),
    .SETTLE_CYCLES (2)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .configs_in (configs_in),
    .configs_en (configs_en),
    .ff_en      (ff_en),
    .rdy        (rdy),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Bench-side tracking of the frame register after word w of a frame.
  task automatic model_word(input int w, input logic [2:0] d);
    for (int b = 0; b < 8; b++) begin
      if (b / 3 == w) exp_cur[b] = d[b % 3];
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_configs_in"}, 32'(configs_in), 32'd0);
    check({tag, "_configs_en"}, 32'(configs_en), 32'd0);
    check({tag, "_ff_en"},      32'(ff_en),      32'd0);
    check({tag, "_rdy"},        32'(rdy),        32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  // One complete pass starting from IDLE or DONE. bp inserts an idle
  // in_valid cycle before every word; noise drives start/in_valid during
  // WRITE and SETTLE, which must have no effect.
  task automatic run_pass(input string tag, input bit bp, input bit noise);
    start = 1'b1;
    tick();                          // IDLE/DONE -> LOAD
    start = 1'b0;
    check({tag, "_entry_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_entry_ff_en"},    32'(ff_en),    32'd0);
    check({tag, "_entry_rdy"},      32'(rdy),      32'd0);
    check({tag, "_entry_busy"},     32'(busy),     32'd1);
    for (int f = 0; f < 4; f++) begin
      for (int w = 0; w < 3; w++) begin
        if (bp) begin
          in_valid = 1'b0;
          in_data  = 3'b010;
          tick();
          check($sformatf("%s_stall_in_ready_f%0d_w%0d", tag, f, w), 32'(in_ready), 32'd1);
          check($sformatf("%s_stall_hold_f%0d_w%0d", tag, f, w), 32'(configs_in), 32'(exp_cur));
        end
        in_valid = 1'b1;
        in_data  = words[f][w];
        tick();
        model_word(w, words[f][w]);
        if (w < 2) begin
          check($sformatf("%s_load_en_f%0d_w%0d", tag, f, w), 32'(configs_en), 32'd0);
          if (bp) check($sformatf("%s_word_f%0d_w%0d", tag, f, w), 32'(configs_in), 32'(exp_cur));
        end
      end
      in_valid = 1'b0;
      // WRITE cycle
      check($sformatf("%s_write_en_f%0d", tag, f),    32'(configs_en), 32'(4'b0001 << f));
      check($sformatf("%s_write_frame_f%0d", tag, f), 32'(configs_in), 32'(exp_frame[f]));
      check($sformatf("%s_write_rdy_f%0d", tag, f),   32'(in_ready),   32'd0);
      if (noise) begin
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 3'b111;
      end
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      check($sformatf("%s_post_write_en_f%0d", tag, f),    32'(configs_en), 32'd0);
      check($sformatf("%s_post_write_frame_f%0d", tag, f), 32'(configs_in), 32'(exp_frame[f]));
      if (f < 3) check($sformatf("%s_next_load_f%0d", tag, f), 32'(in_ready), 32'd1);
    end
    // First SETTLE cycle
    check({tag, "_settle1_ff_en"},    32'(ff_en),    32'd0);
    check({tag, "_settle1_busy"},     32'(busy),     32'd1);
    check({tag, "_settle1_in_ready"}, 32'(in_ready), 32'd0);
    if (noise) begin
      start    = 1'b1;
      in_valid = 1'b1;
    end
    tick();
    check({tag, "_settle2_ff_en"}, 32'(ff_en), 32'd0);
    check({tag, "_settle2_busy"},  32'(busy),  32'd1);
    start    = 1'b0;
    in_valid = 1'b0;
    tick();
    check({tag, "_done1_ff_en"},  32'(ff_en),      32'd1);
    check({tag, "_done1_rdy"},    32'(rdy),        32'd0);
    check({tag, "_done1_busy"},   32'(busy),       32'd0);
    check({tag, "_done1_frame"},  32'(configs_in), 32'(exp_frame[3]));
    tick();
    check({tag, "_done2_ff_en"},  32'(ff_en),      32'd1);
    check({tag, "_done2_rdy"},    32'(rdy),        32'd1);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    exp_cur  = 8'h00;
    words[0] = '{3'b101, 3'b011, 3'b111};
    words[1] = '{3'b010, 3'b110, 3'b001};
    words[2] = '{3'b111, 3'b000, 3'b110};
    words[3] = '{3'b001, 3'b101, 3'b100};
    exp_frame[0] = 8'b11011101;
    exp_frame[1] = 8'b01110010;
    exp_frame[2] = 8'b10000111;
    exp_frame[3] = 8'b00101001;

    // Reset held with start and in_valid active.
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 3'b111;
    #1 rst = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset_hold");
    start    = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset_release");

    // Full-rate pass, then a restart from DONE with stalls, then one with
    // ignored events.
    run_pass("full", 1'b0, 1'b0);
    run_pass("bp", 1'b1, 1'b0);
    run_pass("noise", 1'b0, 1'b1);

    // Reset in the middle of frame 2 LOAD.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 3; w++) begin
        in_valid = 1'b1;
        in_data  = words[f][w];
        tick();
      end
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = words[2][0];
    tick();
    check("midreset_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_idle_outputs("midreset_async");
    exp_cur  = 8'h00;
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("midreset_idle");
    run_pass("after_reset", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
